// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and queued command record
// used by the manager and its command FIFO.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic       HBURST_SINGLE = 1'b0;

    localparam logic [1:0] HSIZE_BYTE  = 2'b00;
    localparam logic [1:0] HSIZE_HALF  = 2'b01;
    localparam logic [1:0] HSIZE_WORD  = 2'b10;
    localparam logic [1:0] HSIZE_DWORD = 2'b11;

    // Storage widths of a queued command; the manager's ADDR_W/DATA_W must not exceed them.
    localparam int CMD_ADDR_MAX = 32;
    localparam int CMD_DATA_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } ahb_state_e;

    typedef struct packed {
        logic                    write;
        logic [CMD_ADDR_MAX-1:0] addr;
        logic [1:0]              size;
        logic [CMD_DATA_MAX-1:0] wdata;
    } ahb_cmd_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous FIFO of AHB command records. The head entry is visible
// combinationally so the address phase can go out the cycle after a push.
module ahb_cmd_fifo
    import ahb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     n_rst,
    input  logic     push,
    input  ahb_cmd_t push_cmd,
    input  logic     pop,
    output ahb_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    ahb_cmd_t       mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;

    // Extra pointer bit tells a wrapped (full) FIFO apart from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
        end
    end

endmodule

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: issues queued single transfers as NONSEQ/SINGLE, overlapping
// the next address phase with the current data phase, and reports one response per command.
module ahb_lite_manager
    import ahb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [1:0]        hsize,
    output logic              hwrite,
    output logic              hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    input  logic              hready
);

    ahb_cmd_t          push_cmd;
    ahb_cmd_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              addr_phase;
    logic [DATA_W-1:0] head_wdata;
    logic              unused_head;

    ahb_state_e        state_q;
    logic              cur_write_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    assign push_cmd.write = cmd_write;
    assign push_cmd.addr  = CMD_ADDR_MAX'(cmd_addr);
    assign push_cmd.size  = cmd_size;
    assign push_cmd.wdata = CMD_DATA_MAX'(cmd_wdata);

    assign head_wdata  = head.wdata[DATA_W-1:0];
    assign unused_head = ^{head.addr, head.wdata};

    assign push = cmd_valid && !fifo_full;
    assign pop  = addr_phase && hready;

    ahb_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // An address phase is offered whenever a command waits, except while an
    // ERROR response is in progress: the pending command is then withdrawn and re-issued later.
    always_comb begin
        addr_phase = 1'b0;
        if (!fifo_empty) begin
            case (state_q)
                ST_IDLE, ST_ADDR: addr_phase = 1'b1;
                ST_DATA:          addr_phase = !hresp;
                default:          addr_phase = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cur_write_q <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ADDR: begin
                    if (pop) begin
                        state_q     <= ST_DATA;
                        cur_write_q <= head.write;
                        hwdata_q    <= head_wdata;
                    end else if (addr_phase) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (hready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= hresp;
                        rsp_rdata_q <= (cur_write_q || hresp) ? '0 : hrdata;
                        if (pop) begin
                            cur_write_q <= head.write;
                            hwdata_q    <= head_wdata;
                        end else begin
                            state_q     <= ST_IDLE;
                            cur_write_q <= 1'b0;
                            hwdata_q    <= '0;
                        end
                    end else if (hresp) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    // Second ERROR cycle closes the transfer.
                    if (hready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_IDLE;
                        cur_write_q <= 1'b0;
                        hwdata_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE) || rsp_valid_q;

    assign hsel   = addr_phase;
    assign htrans = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr  = addr_phase ? head.addr[ADDR_W-1:0] : '0;
    assign hsize  = addr_phase ? head.size : HSIZE_BYTE;
    assign hwrite = addr_phase && head.write;
    assign hburst = HBURST_SINGLE;
    assign hwdata = hwdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/ahb_lite_manager.md
Name: ahb_lite_manager

Overview:
- Synthesizable AHB-Lite manager (initiator) that drives the accelerator's AHB subordinate port.
- Accepts single-transfer commands (read/write, address, size, data) from a local controller through a command FIFO and issues them as NONSEQ/SINGLE transfers.
- Returns read data or an error flag for each command.
- Replaces the bench-only bus driving with on-chip sequencing: weight/input/bias load, activation select, inference start and status polling.

Parameters:
- ADDR_W, 10, haddr width
- DATA_W, 64, hwdata/hrdata width
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept (not full)
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  target address
- cmd_size  input  2  hsize code (00 byte, 01 half, 10 word, 11 dword)
- cmd_wdata  input  DATA_W  write data, driven on hwdata unshifted
- rsp_valid  output  1  one-cycle pulse, command complete
- rsp_rdata  output  DATA_W  hrdata captured for reads, 0 for writes
- rsp_err  output  1  subordinate returned ERROR
- busy  output  1  FIFO non-empty or transfer in flight
- hsel  output  1  subordinate select
- haddr  output  ADDR_W  address phase address
- htrans  output  2  IDLE/NONSEQ
- hsize  output  2  transfer size
- hwrite  output  1  transfer direction
- hburst  output  1  always HBURST_SINGLE
- hwdata  output  DATA_W  data phase write data
- hrdata  input  DATA_W  read data
- hresp  input  1  1=ERROR
- hready  input  1  transfer done / bus ready

Behaviour:
- Reset (async, n_rst=0): FIFO empty, FSM=IDLE. Outputs: hsel=0, htrans=IDLE, haddr=0, hsize=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. cmd_ready=1 after reset release.
- Reset mid-transfer aborts the transfer. No response is emitted and the FIFO is flushed.
- FIFO: push when cmd_valid && cmd_ready. Pop when a command enters its address phase. Simultaneous push and pop when full is not allowed, because cmd_ready=0 when full regardless of pop.
- FSM states:
  - IDLE: bus idle. FIFO non-empty -> ADDR.
  - ADDR: drive hsel=1, htrans=NONSEQ, haddr/hsize/hwrite from the FIFO head. Pop on the same edge. Move to DATA on the first clk edge with hready=1; hold the address phase while hready=0.
  - DATA: hwdata holds the command data for the whole data phase. Outcomes:
    - hready=1 && hresp=0: complete. rsp_valid=1 next cycle, rsp_rdata=hrdata (reads), rsp_err=0.
    - hresp=1 && hready=0: first ERROR cycle -> ERR.
    - hresp=1 && hready=1 seen directly in DATA: treated as complete with rsp_err=1.
  - ERR: htrans=IDLE, hsel=0. No new address phase is issued in this cycle. The second ERROR cycle (hready=1) completes with rsp_err=1, rsp_rdata=0 -> IDLE.
- Pipelining: in DATA, if the FIFO holds another command and no error is in progress, its address phase is driven concurrently (overlapped). On hready=1 the current command completes and the next enters DATA.
  - If the first ERROR cycle occurs while an overlapped address phase is driven, the manager switches htrans to IDLE. The command is not popped; it is re-issued after ERR.
- Between commands with an empty FIFO: hsel=0, htrans=IDLE, hwrite=0.
- Write data is placed on hwdata exactly as given, with no byte-lane steering. Subordinate lane decoding applies.
- One response per accepted command, in order. There is no response backpressure; the consumer must sample rsp_valid.
- Minimum latency: cmd accepted at cycle t -> address phase t+1 -> data phase t+2 -> rsp_valid at t+3, given hready=1 throughout.
- busy = FIFO non-empty || state != IDLE || rsp_valid.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - HBURST_SINGLE=1'b0
  - HSIZE_BYTE/HALF/WORD/DWORD
  - FSM state enum
  - command struct {write, addr, size, wdata}
- Sub-module ahb_cmd_fifo: parameterized synchronous FIFO of command structs with full/empty and async active-low reset.

Test Plan:
- Single write: cmd write addr=0x000 size=11 data=0x0101_0101_0101_0101 -> one NONSEQ with hwrite=1, hwdata equal to data in the following cycle; rsp_valid at t+3, rsp_err=0.
- Single read with wait states: read addr=0x023 size=00, subordinate holds hready=0 for 3 cycles then returns 0x0909_0909_0909_0909 -> rsp_rdata equals that value; rsp_valid exactly 1 cycle.
- Back-to-back: 8 writes to 0x008–0x00F pushed consecutively -> overlapped address/data phases; 8 responses in order; no IDLE cycles between transfers when hready=1; cmd_ready=0 while FIFO holds 4.
- Error with pipelined command: write to 0x022 answered with two-cycle ERROR, next read to 0x023 queued -> htrans=IDLE in the first ERROR cycle; rsp_err=1 for the write; read re-issued and completes with rsp_err=0.
- FIFO full: push 5 commands with hready stuck 0 -> 5th stalled (cmd_ready=0) until the first pop; all 5 eventually complete in order.
- Reset mid-transfer: assert n_rst=0 during a DATA phase with 2 queued -> all outputs return to reset values immediately; no rsp_valid after release; busy=0.
